bp_stall_profile_ctrl: RTL

- Sequencer for the per-core stall-reason counter bank.
- Opens and closes the counting window by gating count enable, and clears the bank on command.
- On a dump, walks the bank through a 1-cycle-latency read port and streams each count, then the window cycle count, to the host over a valid/ready interface.
- Sits between the host command shell and the stall counter bank.

---
 rtl/bp_stall_profile_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bp_stall_profile_ctrl.sv
// Sequencer for the per-core stall-reason counter bank: gates the counting
// window, clears the bank, and streams every count plus elapsed cycles to the host.
module bp_stall_profile_ctrl #(
  parameter int num_reasons_p  = 24,
  parameter int cnt_width_p    = 32,
  parameter int window_width_p = 32,
  parameter int addr_width_lp  = ($clog2(num_reasons_p + 1) < 1) ? 1 : $clog2(num_reasons_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cmd_v_i,
  input  logic [1:0]                cmd_i,
  output logic                      cmd_ready_o,
  input  logic [window_width_p-1:0] window_len_i,
  output logic                      count_en_o,
  output logic                      clear_o,
  output logic [addr_width_lp-1:0]  rd_addr_o,
  input  logic [cnt_width_p-1:0]    rd_data_i,
  output logic                      data_v_o,
  output logic [addr_width_lp-1:0]  data_id_o,
  output logic [cnt_width_p-1:0]    data_o,
  input  logic                      data_ready_i,
  output logic                      done_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] CLEAR    = 3'd2;
  localparam logic [2:0] DUMP_RD  = 3'd3;
  localparam logic [2:0] DUMP_OUT = 3'd4;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;
  localparam logic [1:0] CMD_DUMP  = 2'd3;

  localparam logic [addr_width_lp-1:0]  last_idx_lp = addr_width_lp'(num_reasons_p);
  localparam logic [window_width_p-1:0] win_one_lp  = window_width_p'(1);

  logic [2:0]                state;
  logic [window_width_p-1:0] window;
  logic [window_width_p-1:0] elapsed;
  logic [addr_width_lp-1:0]  index;
  logic [addr_width_lp-1:0]  rd_addr;
  logic [cnt_width_p-1:0]    hold;
  logic                      out_first;
  logic                      clear_r;
  logic                      done_r;
  logic                      cmd_fire;
  logic                      last_word;

  function automatic logic [window_width_p-1:0] sat_inc(input logic [window_width_p-1:0] v);
    sat_inc = (&v) ? v : v + win_one_lp;
  endfunction

  function automatic logic [cnt_width_p-1:0] fit_cnt(input logic [window_width_p-1:0] v);
    fit_cnt = cnt_width_p'(v);
  endfunction

  assign cmd_ready_o = (state == IDLE) || (state == RUN);
  assign cmd_fire    = cmd_v_i && cmd_ready_o;
  assign last_word   = (index == last_idx_lp);
  assign count_en_o  = (state == RUN);
  assign clear_o     = clear_r;
  assign done_o      = done_r;
  assign rd_addr_o   = rd_addr;
  assign data_v_o    = (state == DUMP_OUT);
  assign data_id_o   = index;

  // Bank data arrives in the first DUMP_OUT cycle; afterwards the captured copy is shown.
  always_comb begin
    data_o = '0;
    if (state == DUMP_OUT) begin
      if (last_word)      data_o = fit_cnt(elapsed);
      else if (out_first) data_o = rd_data_i;
      else                data_o = hold;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      window    <= '0;
      elapsed   <= '0;
      index     <= '0;
      rd_addr   <= '0;
      hold      <= '0;
      out_first <= 1'b0;
      clear_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      clear_r   <= 1'b0;
      done_r    <= 1'b0;
      out_first <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd_i)
              CMD_START: begin
                window <= window_len_i;
                state  <= RUN;
              end
              CMD_CLEAR: begin
                clear_r <= 1'b1;
                elapsed <= '0;
                state   <= CLEAR;
              end
              CMD_DUMP: begin
                index   <= '0;
                rd_addr <= '0;
                state   <= DUMP_RD;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          elapsed <= sat_inc(elapsed);
          if (window != '0) window <= window - win_one_lp;
          // An accepted command takes priority over window expiry.
          if (cmd_fire) begin
            case (cmd_i)
              CMD_START: window <= window_len_i;
              CMD_STOP:  state  <= IDLE;
              CMD_CLEAR: begin
                clear_r <= 1'b1;
                elapsed <= '0;
              end
              default: begin
                index   <= '0;
                rd_addr <= '0;
                state   <= DUMP_RD;
              end
            endcase
          end else if (window == win_one_lp) begin
            index   <= '0;
            rd_addr <= '0;
            state   <= DUMP_RD;
          end
        end
        CLEAR: state <= IDLE;
        DUMP_RD: begin
          out_first <= 1'b1;
          state     <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (out_first) hold <= rd_data_i;
          if (data_ready_i) begin
            if (last_word) begin
              done_r <= 1'b1;
              state  <= IDLE;
            end else begin
              index   <= index + addr_width_lp'(1);
              rd_addr <= index + addr_width_lp'(1);
              state   <= DUMP_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
